wino_out_tile_sched: RTL
========================

# wino_out_tile_sched

Tile scheduler for the Winograd F(2x2,3x3) output stage. Accepts a stream of 4x4 element-wise-product tiles (M), drives the existing `output_2x2_transform` datapath one tile at a time, and waits the transform's fixed pipeline latency. It then presents each 2x2 result with its tile coordinates to the output feature-map writer, with backpressure. It sits between the EWMM stage and the output buffer, and runs one layer pass (tiles_y × tiles_x tiles) per `start`.

## Interface
- `W`, 16: element width, signed two's complement.
- `XFORM_LAT`, 2: cycles from M applied at the transform input to Y valid; must be ≥1.
- `TW`, 8: tile-count and coordinate width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a pass; ignored while `busy`.
- `tiles_x` in TW: tiles per row; latched at accepted `start`.
- `tiles_y` in TW: tile rows; latched at accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at pass end.
- `m_valid` in 1: upstream tile valid.
- `m_ready` out 1: scheduler can accept a tile.
- `m_data` in 16*W: 4x4 tile, same packing as the transform's M port.
- `out_valid` out 1: result valid.
- `out_ready` in 1: writer accepts.
- `out_data` out 4*W: 2x2 result, the transform's Y unmodified.
- `out_tile_x` out TW: column index of the result tile.
- `out_tile_y` out TW: row index of the result tile.
- `out_last` out 1: result is the final tile of the pass.

## Operation
- FSM states: IDLE, LOAD, XFORM, WRITE, FIN.
- **IDLE**
  - `start` with `tiles_x`≠0 and `tiles_y`≠0: latch config, clear tx/ty, go to LOAD.
  - `start` with either count 0: go to FIN (no tiles, no `m_ready`).
- **LOAD**
  - `m_ready`=1.
  - On `m_valid`&&`m_ready`: register `m_data` into the transform input register, clear the latency counter, go to XFORM.
- **XFORM**
  - Count `XFORM_LAT` cycles.
  - At terminal count: capture Y into the output register, go to WRITE.
- **WRITE**
  - `out_valid`=1. `out_data`, `out_tile_x`, `out_tile_y` and `out_last` hold stable until `out_ready`.
  - On handshake with `out_last`=1: go to FIN.
  - Otherwise: advance tx (wrap to 0 at `tiles_x`-1 and increment ty), go to LOAD.
- **FIN**
  - `done`=1 for one cycle, then go to IDLE.
- `out_last` = (tx==tiles_x-1)&&(ty==tiles_y-1).
- Only one tile is in flight. `m_ready` is low in every state except LOAD.
- Transform instance: its active-low reset is driven from `~rst`.
- Reset (any state, including mid-tile): next state IDLE.
  - Reset values: `busy`, `done`, `m_ready`, `out_valid`, `out_last` = 0; `out_data`, `out_tile_x`, `out_tile_y` = 0.
  - No `done` is issued for an aborted pass. An in-flight tile is discarded.
- `start` while `busy`: ignored, config not re-latched.
- `tiles_x`/`tiles_y` changes after `start`: no effect until the next pass.

## Timing
- `start` accepted at cycle 0:
  - `busy`=1 and `m_ready`=1 from cycle 1.
  - Zero-tile case: `done` at cycle 1, `busy` stays 0.
- Input handshake at cycle t: `out_valid`=1 from cycle t+XFORM_LAT+1 (t+3 at default).
- Output handshake at cycle u:
  - Not last: `out_valid`=0 and `m_ready`=1 at u+1.
  - Last: `done`=1 at u+1, `busy`=0 at u+2.
- Minimum period per tile with no stalls: XFORM_LAT+2 cycles.
- All outputs are registered. No combinational path from `m_valid` or `out_ready` to any output.

## Structure
- Shared package `wino_pkg`:
  - FSM state enum.
  - Tile dimensions: M 4x4, Y 2x2.
  - Default `W`.
  - Packing-width constants (16*W, 4*W).
- One sub-module: the existing `output_2x2_transform` instance.
- The tile coordinate counter stays inline.

## Test plan
- Reset, then `start` with tiles_x=1, tiles_y=1, and M with all 16 elements = 1 (tile applied one cycle later):
  - Expected Y: [0][0]=0x0009, [0][1]=0xFFFD, [1][0]=0xFFFD, [1][1]=0x0001.
  - `out_valid` exactly 3 cycles after the input handshake, `out_last`=1, `done` on the cycle after the output handshake.
- tiles_x=3, tiles_y=2, `out_ready` held 1:
  - 6 results with (x,y) order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - `out_last` only on (2,1).
  - Exactly one `done`.
- `out_ready` held 0 for 5 cycles during WRITE:
  - `out_data` and coordinates stable throughout.
  - `m_ready` stays 0; the next tile is accepted only after the release.
- tiles_x=0, tiles_y=4:
  - `done` at cycle 1, no `m_ready` and no `out_valid` ever.
- `rst` asserted during XFORM of tile 2 of 4:
  - All outputs 0 next cycle, no `done`.
  - A new `start` (1x1) then completes normally.
- Second `start` pulsed mid-pass with different counts:
  - Ignored; the pass completes with the original tile count.

Source files
------------

// File: rtl/wino_pkg.sv
// ============================================================================
//  Module      : wino_pkg
//  Description : Shared types and constants for the Winograd F(2x2,3x3)
//                output-stage tile scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wino_pkg;

  localparam int c_W_DEF    = 16;
  localparam int c_M_DIM    = 4;
  localparam int c_Y_DIM    = 2;
  localparam int c_M_ELEMS  = c_M_DIM * c_M_DIM;
  localparam int c_Y_ELEMS  = c_Y_DIM * c_Y_DIM;
  localparam int c_M_BITS   = c_M_ELEMS * c_W_DEF;
  localparam int c_Y_BITS   = c_Y_ELEMS * c_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_XFORM = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/output_2x2_transform.sv
// ============================================================================
//  Module      : output_2x2_transform
//  Description : Y = A^T * M * A for Winograd F(2x2,3x3); STAGES output
//                pipeline registers behind the combinational datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module output_2x2_transform
  import wino_pkg::*;
#(
  parameter int W      = c_W_DEF,
  parameter int STAGES = 1
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [c_M_ELEMS*W-1:0] i_m,
  output logic [c_Y_ELEMS*W-1:0] o_y
);

  logic signed [W-1:0]    w_m  [c_M_ELEMS];
  logic signed [W-1:0]    w_t0 [c_M_DIM];
  logic signed [W-1:0]    w_t1 [c_M_DIM];
  logic [c_Y_ELEMS*W-1:0] w_y;

  // Element (r,c) lives at bits [(r*4+c)*W +: W]; results wrap to W bits.
  always_comb begin
    for (int i = 0; i < c_M_ELEMS; i++) begin
      w_m[i] = i_m[i*W +: W];
    end
    for (int c = 0; c < c_M_DIM; c++) begin
      w_t0[c] = w_m[c] + w_m[4+c] + w_m[8+c];
      w_t1[c] = w_m[4+c] - w_m[8+c] - w_m[12+c];
    end
    w_y = {w_t1[1] - w_t1[2] - w_t1[3],
           w_t1[0] + w_t1[1] + w_t1[2],
           w_t0[1] - w_t0[2] - w_t0[3],
           w_t0[0] + w_t0[1] + w_t0[2]};
  end

  generate
    if (STAGES == 0) begin : g_comb
      assign o_y = w_y;
    end else begin : g_pipe
      logic [c_Y_ELEMS*W-1:0] r_pipe [STAGES];

      always_ff @(posedge clk) begin
        if (!i_rst_n) begin
          for (int s = 0; s < STAGES; s++) begin
            r_pipe[s] <= '0;
          end
        end else begin
          r_pipe[0] <= w_y;
          for (int s = 1; s < STAGES; s++) begin
            r_pipe[s] <= r_pipe[s-1];
          end
        end
      end

      assign o_y = r_pipe[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wino_out_tile_sched.sv
// ============================================================================
//  Module      : wino_out_tile_sched
//  Description : Feeds 4x4 M tiles one at a time through the output transform
//                and presents each 2x2 result with its tile coordinates.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wino_out_tile_sched
  import wino_pkg::*;
#(
  parameter int W         = c_W_DEF,
  parameter int XFORM_LAT = 2,
  parameter int TW        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TW-1:0]          tiles_x,
  input  logic [TW-1:0]          tiles_y,
  output logic                   busy,
  output logic                   done,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [c_M_ELEMS*W-1:0] m_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [c_Y_ELEMS*W-1:0] out_data,
  output logic [TW-1:0]          out_tile_x,
  output logic [TW-1:0]          out_tile_y,
  output logic                   out_last
);

  localparam int              c_LCW      = (XFORM_LAT > 1) ? $clog2(XFORM_LAT) : 1;
  localparam logic [c_LCW-1:0] c_LAT_TERM = c_LCW'(XFORM_LAT - 1);

  sched_state_t           r_state;
  sched_state_t           w_next;
  logic [TW-1:0]          r_tiles_x;
  logic [TW-1:0]          r_tiles_y;
  logic [TW-1:0]          r_tx;
  logic [TW-1:0]          r_ty;
  logic [c_LCW-1:0]       r_lat_cnt;
  logic [c_M_ELEMS*W-1:0] r_m_in;
  logic [c_Y_ELEMS*W-1:0] w_y;
  logic                   w_rst_n;
  logic                   w_start_ok;
  logic                   w_lat_term;
  logic                   w_tx_wrap;
  logic                   w_is_last;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_m_ready;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [c_Y_ELEMS*W-1:0] r_out_data;
  logic [TW-1:0]          r_out_tx;
  logic [TW-1:0]          r_out_ty;

  assign w_rst_n    = ~rst;
  assign w_start_ok = start && (tiles_x != '0) && (tiles_y != '0);
  assign w_lat_term = (r_lat_cnt == c_LAT_TERM);
  assign w_tx_wrap  = (r_tx == r_tiles_x - TW'(1));
  assign w_is_last  = w_tx_wrap && (r_ty == r_tiles_y - TW'(1));

  output_2x2_transform #(
    .W      (W),
    .STAGES (XFORM_LAT - 1)
  ) u_xform (
    .clk     (clk),
    .i_rst_n (w_rst_n),
    .i_m     (r_m_in),
    .o_y     (w_y)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_start_ok ? S_LOAD : S_FIN;
        end
      end
      S_LOAD: begin
        if (m_valid) begin
          w_next = S_XFORM;
        end
      end
      S_XFORM: begin
        if (w_lat_term) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (out_ready) begin
          w_next = r_out_last ? S_FIN : S_LOAD;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so nothing downstream
  // sees a combinational path from m_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_m_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_tx    <= '0;
      r_out_ty    <= '0;
      r_tiles_x   <= '0;
      r_tiles_y   <= '0;
      r_tx        <= '0;
      r_ty        <= '0;
      r_lat_cnt   <= '0;
      r_m_in      <= '0;
    end else begin
      r_state     <= w_next;
      r_m_ready   <= (w_next == S_LOAD);
      r_out_valid <= (w_next == S_WRITE);
      r_done      <= (w_next == S_FIN);
      // A zero-tile pass goes IDLE->FIN and never raises busy.
      r_busy      <= (w_next == S_LOAD) || (w_next == S_XFORM) ||
                     (w_next == S_WRITE) ||
                     ((w_next == S_FIN) && (r_state == S_WRITE));

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_tiles_x <= tiles_x;
            r_tiles_y <= tiles_y;
            r_tx      <= '0;
            r_ty      <= '0;
          end
        end
        S_LOAD: begin
          if (m_valid) begin
            r_m_in    <= m_data;
            r_lat_cnt <= '0;
          end
        end
        S_XFORM: begin
          r_lat_cnt <= r_lat_cnt + c_LCW'(1);
          if (w_lat_term) begin
            r_out_data <= w_y;
            r_out_tx   <= r_tx;
            r_out_ty   <= r_ty;
            r_out_last <= w_is_last;
          end
        end
        S_WRITE: begin
          if (out_ready && !r_out_last) begin
            if (w_tx_wrap) begin
              r_tx <= '0;
              r_ty <= r_ty + TW'(1);
            end else begin
              r_tx <= r_tx + TW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign m_ready    = r_m_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_tile_x = r_out_tx;
  assign out_tile_y = r_out_ty;
  assign out_last   = r_out_last;

endmodule

`default_nettype wire
